// File: rtl/trapezoid_feeder_if.sv
// ---------------------------------------------------------------------------
// trapezoid_feeder_if
//   Descriptor channel between the host/command logic and trapezoid_feeder.
//   One descriptor is transferred on every rising clock edge where
//   desc_valid and desc_ready are both high.
//
//   desc_valid  host -> feeder   descriptor offered
//   desc_ready  feeder -> host   feeder can take a descriptor this cycle
//   desc_x      host -> feeder   {x1,x2,x3,x4}, x1 in [31:24]
//   desc_y      host -> feeder   {y1,y2,y3,y4}, y1 in [31:24]
//
//   master: the side that produces descriptors (host)
//   slave : the side that consumes descriptors (trapezoid_feeder)
// ---------------------------------------------------------------------------
interface trapezoid_feeder_if;
  logic        desc_valid;
  logic        desc_ready;
  logic [31:0] desc_x;
  logic [31:0] desc_y;

  modport master (
    output desc_valid,
    output desc_x,
    output desc_y,
    input  desc_ready
  );

  modport slave (
    input  desc_valid,
    input  desc_x,
    input  desc_y,
    output desc_ready
  );
endinterface

// File: rtl/trapezoid_feeder.sv
// ---------------------------------------------------------------------------
// trapezoid_feeder
//   Host-side sequencer for the trapezoid renderer. Descriptors are queued in
//   a small FIFO; each one is sent to the renderer as an nt strobe followed by
//   four vertices on xi/yi. The renderer's pixel stream (po/xo/yo) is then
//   counted and bounds-checked against the vertex bounding box, and a
//   one-cycle done pulse reports the result of every trapezoid.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   desc         descriptor channel (slave side of trapezoid_feeder_if)
//   nt           new-trapezoid strobe to the renderer (one cycle per shape)
//   xi, yi       vertex coordinate to the renderer
//   busy         renderer busy
//   po, xo, yo   renderer pixel valid / x / y
//   done         one-cycle pulse, result fields valid in the same cycle
//   pix_cnt      pixels received for the last trapezoid (saturating)
//   err_oob      last trapezoid produced at least one pixel outside its bbox
//   err_timeout  last trapezoid hit the busy-wait or render time limit
//
// Timing summary
//   Descriptor accepted into an empty FIFO with busy low: nt is high two
//   cycles later, followed by vertices 2..4 on consecutive cycles. done and
//   the result fields are registered on entry to REPORT, so done is high
//   exactly during the REPORT cycle.
// ---------------------------------------------------------------------------
module trapezoid_feeder #(
  parameter int DEPTH        = 4,
  parameter int CNT_W        = 16,
  parameter int WAIT_LIMIT   = 16,
  parameter int RENDER_LIMIT = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  trapezoid_feeder_if.slave    desc,
  output logic                 nt,
  output logic [7:0]           xi,
  output logic [7:0]           yi,
  input  logic                 busy,
  input  logic                 po,
  input  logic [7:0]           xo,
  input  logic [7:0]           yo,
  output logic                 done,
  output logic [CNT_W-1:0]     pix_cnt,
  output logic                 err_oob,
  output logic                 err_timeout
);

  localparam int AW     = $clog2(DEPTH);
  localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);
  localparam int REN_W  = $clog2(RENDER_LIMIT + 1);

  // Last counter value before the limit is reached; the transition happens
  // on the edge that would bring the counter to the limit.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);
  localparam logic [REN_W-1:0]  REN_LAST  = REN_W'(RENDER_LIMIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    RENDER,
    REPORT
  } state_t;

  // -------------------------------------------------------------------------
  // Descriptor FIFO
  // -------------------------------------------------------------------------
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [63:0]  fifo_mem [DEPTH];
  logic [63:0]  head;
  logic         fifo_empty;
  logic         fifo_full;
  logic         ready_en_q;
  logic         desc_ready_int;
  logic         push;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // ready_en_q keeps desc_ready low while reset is asserted and until the
  // first clock edge after release.
  assign desc_ready_int  = ready_en_q & ~fifo_full;
  assign desc.desc_ready = desc_ready_int;
  assign push            = desc.desc_valid & desc_ready_int;
  assign head            = fifo_mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= {desc.desc_x, desc.desc_y};
    end
  end

  // -------------------------------------------------------------------------
  // Vertex unpacking and bounding box of the FIFO head
  // -------------------------------------------------------------------------
  logic [31:0] desc_x_q, desc_x_d;
  logic [31:0] desc_y_q, desc_y_d;
  logic [7:0]  head_x [4];
  logic [7:0]  head_y [4];
  logic [7:0]  cur_x  [4];
  logic [7:0]  cur_y  [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_vtx
      // Vertex 1 lives in the most significant byte.
      assign head_x[gi] = head[63-8*gi -: 8];
      assign head_y[gi] = head[31-8*gi -: 8];
      assign cur_x[gi]  = desc_x_q[31-8*gi -: 8];
      assign cur_y[gi]  = desc_y_q[31-8*gi -: 8];
    end
  endgenerate

  logic [7:0] head_xmin, head_xmax, head_ymin, head_ymax;

  always_comb begin
    head_xmin = head_x[0];
    head_xmax = head_x[0];
    head_ymin = head_y[0];
    head_ymax = head_y[0];
    for (int i = 1; i < 4; i++) begin
      if (head_x[i] < head_xmin) head_xmin = head_x[i];
      if (head_x[i] > head_xmax) head_xmax = head_x[i];
      if (head_y[i] < head_ymin) head_ymin = head_y[i];
      if (head_y[i] > head_ymax) head_ymax = head_y[i];
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer state
  // -------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [7:0]         xmin_q, xmin_d, xmax_q, xmax_d;
  logic [7:0]         ymin_q, ymin_d, ymax_q, ymax_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [REN_W-1:0]   ren_cnt_q, ren_cnt_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic               oob_acc_q, oob_acc_d;

  logic               nt_q, nt_d;
  logic [7:0]         xi_q, xi_d;
  logic [7:0]         yi_q, yi_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic               err_oob_q, err_oob_d;
  logic               err_timeout_q, err_timeout_d;

  logic               finish;
  logic               timeout_hit;
  logic               pix_oob;

  assign pix_oob = (xo < xmin_q) || (xo > xmax_q) ||
                   (yo < ymin_q) || (yo > ymax_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ready_en_q    <= 1'b0;
      state_q       <= IDLE;
      idx_q         <= '0;
      desc_x_q      <= '0;
      desc_y_q      <= '0;
      xmin_q        <= '0;
      xmax_q        <= '0;
      ymin_q        <= '0;
      ymax_q        <= '0;
      wait_cnt_q    <= '0;
      ren_cnt_q     <= '0;
      acc_q         <= '0;
      oob_acc_q     <= 1'b0;
      nt_q          <= 1'b0;
      xi_q          <= '0;
      yi_q          <= '0;
      done_q        <= 1'b0;
      pix_cnt_q     <= '0;
      err_oob_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ready_en_q    <= 1'b1;
      state_q       <= state_d;
      idx_q         <= idx_d;
      desc_x_q      <= desc_x_d;
      desc_y_q      <= desc_y_d;
      xmin_q        <= xmin_d;
      xmax_q        <= xmax_d;
      ymin_q        <= ymin_d;
      ymax_q        <= ymax_d;
      wait_cnt_q    <= wait_cnt_d;
      ren_cnt_q     <= ren_cnt_d;
      acc_q         <= acc_d;
      oob_acc_q     <= oob_acc_d;
      nt_q          <= nt_d;
      xi_q          <= xi_d;
      yi_q          <= yi_d;
      done_q        <= done_d;
      pix_cnt_q     <= pix_cnt_d;
      err_oob_q     <= err_oob_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    wr_ptr_d      = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d      = rd_ptr_q;
    desc_x_d      = desc_x_q;
    desc_y_d      = desc_y_q;
    xmin_d        = xmin_q;
    xmax_d        = xmax_q;
    ymin_d        = ymin_q;
    ymax_d        = ymax_q;
    wait_cnt_d    = wait_cnt_q;
    ren_cnt_d     = ren_cnt_q;
    acc_d         = acc_q;
    oob_acc_d     = oob_acc_q;
    nt_d          = 1'b0;
    xi_d          = xi_q;
    yi_d          = yi_q;
    done_d        = 1'b0;
    pix_cnt_d     = pix_cnt_q;
    err_oob_d     = err_oob_q;
    err_timeout_d = err_timeout_q;
    finish        = 1'b0;
    timeout_hit   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Only start a new shape once the renderer has dropped busy.
        if (!fifo_empty && !busy) begin
          state_d   = SEND;
          idx_d     = 2'd0;
          rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, 1'b1};
          desc_x_d  = head[63:32];
          desc_y_d  = head[31:0];
          xmin_d    = head_xmin;
          xmax_d    = head_xmax;
          ymin_d    = head_ymin;
          ymax_d    = head_ymax;
          acc_d     = '0;
          oob_acc_d = 1'b0;
        end
      end

      SEND: begin
        // Outputs are registered, so vertex idx_q appears on xi/yi one
        // cycle after this state slot; the last vertex then stays put.
        nt_d = (idx_q == 2'd0);
        xi_d = cur_x[idx_q];
        yi_d = cur_y[idx_q];
        if (idx_q == 2'd3) begin
          state_d    = WAIT_BUSY;
          wait_cnt_d = '0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end

      WAIT_BUSY: begin
        if (busy) begin
          state_d    = RENDER;
          wait_cnt_d = '0;
          ren_cnt_d  = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_hit = 1'b1;
          finish      = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      RENDER: begin
        if (po) begin
          if (acc_q != {CNT_W{1'b1}}) begin
            acc_d = acc_q + CNT_W'(1);
          end
          if (pix_oob) begin
            oob_acc_d = 1'b1;
          end
        end
        // busy low ends the shape normally even on the limit cycle; the pixel
        // accepted above in this same cycle is still part of the result.
        if (!busy) begin
          finish = 1'b1;
        end else if (ren_cnt_q == REN_LAST) begin
          timeout_hit = 1'b1;
          finish      = 1'b1;
        end else begin
          ren_cnt_d = ren_cnt_q + REN_W'(1);
        end
      end

      REPORT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Results are captured on the way into REPORT so that done and the
    // result fields line up during the REPORT cycle.
    if (finish) begin
      state_d       = REPORT;
      done_d        = 1'b1;
      pix_cnt_d     = acc_d;
      err_oob_d     = oob_acc_d;
      err_timeout_d = timeout_hit;
    end
  end

  assign nt          = nt_q;
  assign xi          = xi_q;
  assign yi          = yi_q;
  assign done        = done_q;
  assign pix_cnt     = pix_cnt_q;
  assign err_oob     = err_oob_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_trapezoid_feeder.sv
// ---------------------------------------------------------------------------
// tb_trapezoid_feeder
//   Directed bench for trapezoid_feeder. The main initial block plays both
//   the host and a simple renderer; a monitor checks the vertex stream and
//   done results against queues filled when stimulus is driven.
// ---------------------------------------------------------------------------
module tb_trapezoid_feeder;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [CNT_W-1:0] pix;
    logic             oob;
    logic             tmo;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             busy = 1'b0;
  logic             po = 1'b0;
  logic [7:0]       xo = 8'd0;
  logic [7:0]       yo = 8'd0;
  logic             nt;
  logic [7:0]       xi;
  logic [7:0]       yi;
  logic             done;
  logic [CNT_W-1:0] pix_cnt;
  logic             err_oob;
  logic             err_timeout;

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int done_exp = 0;

  logic [63:0] exp_vtx_q[$];
  res_t        exp_res_q[$];

  trapezoid_feeder_if dif();

  always #5 clk = ~clk;

  trapezoid_feeder #(
    .DEPTH        (4),
    .CNT_W        (CNT_W),
    .WAIT_LIMIT   (16),
    .RENDER_LIMIT (65535)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .desc        (dif),
    .nt          (nt),
    .xi          (xi),
    .yi          (yi),
    .busy        (busy),
    .po          (po),
    .xo          (xo),
    .yo          (yo),
    .done        (done),
    .pix_cnt     (pix_cnt),
    .err_oob     (err_oob),
    .err_timeout (err_timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bbox_of(input logic [31:0] dx, input logic [31:0] dy);
    logic [7:0] xmn, xmx, ymn, ymx, vx, vy;
    xmn = 8'hff; xmx = 8'h00; ymn = 8'hff; ymx = 8'h00;
    for (int k = 0; k < 4; k++) begin
      vx = dx[31-8*k -: 8];
      vy = dy[31-8*k -: 8];
      if (vx < xmn) xmn = vx;
      if (vx > xmx) xmx = vx;
      if (vy < ymn) ymn = vy;
      if (vy > ymx) ymx = vy;
    end
    return {xmn, xmx, ymn, ymx};
  endfunction

  // Monitor: vertex sequence after each nt, and result fields at each done.
  initial begin : monitor
    int          idx;
    logic [63:0] cur;
    res_t        r;
    idx = 4;
    cur = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        idx = 4;
      end else begin
        if (nt) begin
          if (exp_vtx_q.size() == 0) begin
            check("nt_unexpected_queue_size", exp_vtx_q.size(), 1);
          end else begin
            cur = exp_vtx_q.pop_front();
            idx = 0;
          end
        end
        if (idx < 4) begin
          $display("vertex %0d: xi=%0d yi=%0d nt=%0b", idx, xi, yi, nt);
          check($sformatf("xi_v%0d", idx), xi, cur[63-8*idx -: 8]);
          check($sformatf("yi_v%0d", idx), yi, cur[31-8*idx -: 8]);
          if (idx != 0) check($sformatf("nt_low_v%0d", idx), nt, 0);
          idx++;
        end
        if (done) begin
          done_seen++;
          $display("done: pix_cnt=%0d err_oob=%0b err_timeout=%0b", pix_cnt, err_oob, err_timeout);
          if (exp_res_q.size() == 0) begin
            check("done_unexpected_queue_size", exp_res_q.size(), 1);
          end else begin
            r = exp_res_q.pop_front();
            check("pix_cnt", pix_cnt, r.pix);
            check("err_oob", err_oob, r.oob);
            check("err_timeout", err_timeout, r.tmo);
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic push_desc(input logic [31:0] x, input logic [31:0] y);
    int n;
    n = 0;
    dif.desc_valid = 1'b1;
    dif.desc_x     = x;
    dif.desc_y     = y;
    while (!dif.desc_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("push_accepted", dif.desc_ready, 1);
    if (dif.desc_ready) begin
      exp_vtx_q.push_back({x, y});
      $display("push desc x=%08h y=%08h", x, y);
    end
    @(negedge clk);
    dif.desc_valid = 1'b0;
  endtask

  task automatic wait_nt(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!nt && n < 100);
    check("nt_within_bound", nt, 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_within_bound", done, 1);
    @(negedge clk);
  endtask

  // Called at the nt negedge: let vertices 2..4 pass, raise busy, and offer a
  // stray pixel while the DUT is still waiting for busy (must be ignored).
  task automatic start_busy();
    repeat (3) @(negedge clk);
    busy = 1'b1;
    po   = 1'b1;
    xo   = 8'hff;
    yo   = 8'hff;
    @(negedge clk);
    po   = 1'b0;
  endtask

  // Emit npix pixels (the last nbad outside the bbox), drop busy with the
  // last pixel, and wait for done.
  task automatic finish_render(input logic [31:0] dx, input logic [31:0] dy,
                               input int npix, input int nbad);
    logic [31:0] bb;
    logic [7:0]  xmn, xmx, ymn, ymx;
    int          w, h;
    res_t        r;
    bb  = bbox_of(dx, dy);
    xmn = bb[31:24]; xmx = bb[23:16]; ymn = bb[15:8]; ymx = bb[7:0];
    w   = int'(xmx) - int'(xmn) + 1;
    h   = int'(ymx) - int'(ymn) + 1;
    r.pix = (npix > SAT) ? CNT_W'(SAT) : CNT_W'(npix);
    r.oob = (nbad > 0);
    r.tmo = 1'b0;
    exp_res_q.push_back(r);
    done_exp++;
    if (npix == 0) begin
      @(negedge clk);
      busy = 1'b0;
      po   = 1'b0;
    end
    for (int i = 0; i < npix; i++) begin
      @(negedge clk);
      po = 1'b1;
      if (i >= npix - nbad) begin
        xo = xmx + 8'd1;
        yo = ymn;
      end else if (i == 0) begin
        xo = xmx;
        yo = ymx;
      end else begin
        xo = xmn + 8'((i - 1) % w);
        yo = ymn + 8'((i - 1) % h);
      end
      busy = (i != npix - 1);
    end
    @(negedge clk);
    po = 1'b0;
    wait_done();
  endtask

  task automatic serve(input logic [31:0] dx, input logic [31:0] dy,
                       input int npix, input int nbad);
    int n;
    push_desc(dx, dy);
    wait_nt(n);
    check("nt_latency", n, 2);
    start_busy();
    finish_render(dx, dy, npix, nbad);
  endtask

  localparam logic [31:0] D1X = 32'h0A14_0519;  // {10,20,5,25}
  localparam logic [31:0] D1Y = 32'h0000_0404;  // {0,0,4,4}

  initial begin : main
    logic [31:0] tx [5];
    logic [31:0] ty [5];
    int          n;

    dif.desc_valid = 1'b0;
    dif.desc_x     = '0;
    dif.desc_y     = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", {nt, xi, yi, done, pix_cnt, err_oob, err_timeout, dif.desc_ready}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", dif.desc_ready, 1);

    // 1: in-bbox pixels, including both bbox corners
    serve(D1X, D1Y, 5, 0);
    // 2: one pixel outside the bbox, still counted
    serve(D1X, D1Y, 2, 1);
    // zero pixels
    serve(D1X, D1Y, 0, 0);

    // 3: five descriptors while the renderer is stalled on the first
    for (int i = 0; i < 5; i++) begin
      tx[i] = {8'(i + 1), 8'(i + 3), 8'(i), 8'(i + 4)};
      ty[i] = {8'(2 * i), 8'(2 * i), 8'(2 * i + 3), 8'(2 * i + 3)};
    end
    push_desc(tx[0], ty[0]);
    wait_nt(n);
    check("nt_latency_q0", n, 2);
    start_busy();
    for (int i = 1; i < 5; i++) push_desc(tx[i], ty[i]);
    check("ready_low_when_full", dif.desc_ready, 0);
    dif.desc_valid = 1'b1;
    dif.desc_x     = 32'h5555_5555;
    dif.desc_y     = 32'h6666_6666;
    repeat (3) @(negedge clk);
    check("ready_stays_low_full", dif.desc_ready, 0);
    dif.desc_valid = 1'b0;
    finish_render(tx[0], ty[0], 1, 0);
    for (int i = 1; i < 5; i++) begin
      wait_nt(n);
      start_busy();
      finish_render(tx[i], ty[i], i + 1, 0);
    end

    // 4: renderer never raises busy
    push_desc(D1X, D1Y);
    wait_nt(n);
    exp_res_q.push_back('{pix: '0, oob: 1'b0, tmo: 1'b1});
    done_exp++;
    repeat (3) @(negedge clk);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", n, 16);
    check("xi_holds_last", xi, 25);
    check("yi_holds_last", yi, 4);
    @(negedge clk);

    // 5: reset in the middle of RENDER
    push_desc(D1X, D1Y);
    wait_nt(n);
    start_busy();
    @(negedge clk);
    po = 1'b1;
    xo = 8'd12;
    yo = 8'd2;
    @(negedge clk);
    po = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("reset_midrender_outputs",
             {nt, xi, yi, done, pix_cnt, err_oob, err_timeout, dif.desc_ready}, 0);
    busy = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_midreset", dif.desc_ready, 1);
    serve(D1X, D1Y, 3, 0);

    // 6: counter saturation
    serve(D1X, D1Y, SAT + 4, 0);

    repeat (5) @(negedge clk);
    check("done_count", done_seen, done_exp);
    check("vtx_queue_empty", exp_vtx_q.size(), 0);
    check("res_queue_empty", exp_res_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
